// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and helpers for the board debug front-end
package debug_pkg;

  typedef enum logic [1:0] {
    LED_OFF    = 2'd0,
    LED_ON     = 2'd1,
    LED_BLINK  = 2'd2,
    LED_FOLLOW = 2'd3
  } led_mode_t;

  localparam int unsigned NUM_LEDS = 3;

  // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic led_lit(input led_mode_t mode, input logic blink, input logic follow);
    logic lit;
    case (mode)
      LED_ON:     lit = 1'b1;
      LED_BLINK:  lit = blink;
      LED_FOLLOW: lit = follow;
      default:    lit = 1'b0;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, debounce counter and press/release pulses for one button
module btn_debounce
  import debug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Synchroniser holds raw pin polarity; normalise to 1 = pressed afterwards.
  assign level = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (level != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d  = level;
        press_d   = level;
        release_d = ~level;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= {2{ACTIVE_LOW}};
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw};
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_state   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/debug_panel.sv
// rtl/debug_panel.sv - debounced buttons, press counters, mode-driven RGB LEDs and debug bus
module debug_panel
  import debug_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned BLINK_DIV       = 12000000,
  parameter int unsigned BITS_W          = 8,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned LED_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_state,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  input  logic [5:0]          led_mode,
  output logic                red,
  output logic                green,
  output logic                blue,
  input  logic                bits_mode,
  input  logic [2:0]          bits_sel,
  input  logic                cnt_clr,
  output logic [BITS_W-1:0]   bits
);

  localparam int unsigned DW    = cnt_width(BLINK_DIV);
  localparam logic        UNLIT = (LED_ACTIVE_LOW != 0);

  logic [BITS_W-1:0] press_cnt [NUM_BTNS];

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    logic [BITS_W-1:0] cnt_q, cnt_d;

    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW != 0)
    ) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[g]),
      .btn_state   (btn_state[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g])
    );

    // Clear wins over a coincident press; the press is dropped, not deferred.
    always_comb begin
      cnt_d = cnt_q + BITS_W'(btn_press[g]);
      if (cnt_clr) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign press_cnt[g] = cnt_q;
  end

  logic [DW-1:0] div_q, div_d;
  logic          blink_q, blink_d;

  always_comb begin
    div_d   = div_q + DW'(1);
    blink_d = blink_q;
    if (div_q == DW'(BLINK_DIV - 1)) begin
      div_d   = '0;
      blink_d = ~blink_q;
    end
  end

  logic [NUM_LEDS-1:0] lit_d, led_q;

  for (genvar l = 0; l < NUM_LEDS; l++) begin : g_led
    assign lit_d[l] = led_lit(led_mode_t'(led_mode[2*l +: 2]), blink_q, btn_state[l % NUM_BTNS]);
  end

  logic [BITS_W-1:0] cnt_sel, bits_d, bits_q;

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (bits_sel == 3'(i)) cnt_sel = press_cnt[i];
    end
    bits_d = bits_mode ? cnt_sel : BITS_W'(btn_state);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      blink_q <= 1'b0;
      led_q   <= {NUM_LEDS{UNLIT}};
      bits_q  <= '0;
    end else begin
      div_q   <= div_d;
      blink_q <= blink_d;
      led_q   <= lit_d ^ {NUM_LEDS{UNLIT}};
      bits_q  <= bits_d;
    end
  end

  assign red   = led_q[0];
  assign green = led_q[1];
  assign blue  = led_q[2];
  assign bits  = bits_q;

endmodule

// File: tb/tb_debug_panel.sv
// tb/tb_debug_panel.sv - self-checking bench for debug_panel
module tb_debug_panel;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int BD = 8;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_state, btn_press, btn_release;
  logic [5:0]    led_mode;
  logic          red, green, blue;
  logic          bits_mode;
  logic [2:0]    bits_sel;
  logic          cnt_clr;
  logic [BW-1:0] bits;

  always #5 clk = ~clk;

  debug_panel #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD), .BITS_W(BW),
    .BTN_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .led_mode(led_mode), .red(red), .green(green), .blue(blue),
    .bits_mode(bits_mode), .bits_sel(bits_sel), .cnt_clr(cnt_clr), .bits(bits)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: levels seen by the debouncer lag the pin by two samples; a
  // new level is accepted once the last DB samples all disagree with the held
  // level and all fall after the previous acceptance (or reset).
  logic [NB-1:0] m_s0, m_s1, m_state, m_press, m_rel;
  logic [DB-1:0] m_hist [NB];
  int            m_since [NB];
  int            m_cnt [NB];
  int            m_n;
  logic [2:0]    m_leds;
  logic [BW-1:0] m_bits;

  task automatic model_step();
    logic [BW-1:0] nb;
    logic [2:0]    nl;
    logic          used, phase, lit;
    int            mode;
    if (!rst_n) begin
      m_s0 = '0; m_s1 = '0; m_state = '0; m_press = '0; m_rel = '0;
      for (int b = 0; b < NB; b++) begin m_hist[b] = '0; m_since[b] = 0; m_cnt[b] = 0; end
      m_n = 0; m_leds = 3'b111; m_bits = '0;
      return;
    end
    phase = ((m_n / BD) % 2) == 1;
    nb = '0;
    if (!bits_mode) nb = BW'(m_state);
    else if (int'(bits_sel) < NB) nb = BW'(m_cnt[int'(bits_sel)]);
    for (int i = 0; i < 3; i++) begin
      mode = int'(led_mode[2*i +: 2]);
      lit = (mode == 1) || (mode == 2 && phase) || (mode == 3 && m_state[i % NB]);
      nl[i] = !lit;
    end
    for (int b = 0; b < NB; b++) begin
      m_cnt[b] = cnt_clr ? 0 : (m_cnt[b] + int'(m_press[b])) % (1 << BW);
      used = m_s1[b];
      m_s1[b] = m_s0[b];
      m_s0[b] = !btn_raw[b];
      m_hist[b] = {m_hist[b][DB-2:0], used};
      m_since[b]++;
      m_press[b] = 1'b0;
      m_rel[b] = 1'b0;
      if (m_since[b] >= DB && m_hist[b] == {DB{~m_state[b]}}) begin
        m_state[b] = ~m_state[b];
        if (m_state[b]) m_press[b] = 1'b1;
        else m_rel[b] = 1'b1;
        m_since[b] = 0;
      end
    end
    m_leds = nl;
    m_bits = nb;
    m_n++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("btn_state", btn_state, m_state);
    check("btn_press", btn_press, m_press);
    check("btn_release", btn_release, m_rel);
    check("leds_bgr", {blue, green, red}, m_leds);
    check("bits", bits, m_bits);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_pulse(input string name, input bit rel, input int b, input int lat, input int win);
    int first = -1;
    int n = 0;
    for (int c = 1; c <= win; c++) begin
      tick();
      if (rel ? btn_release[b] : btn_press[b]) begin
        n++;
        if (first < 0) first = c;
      end
    end
    check({name, "_latency"}, first, lat);
    check({name, "_count"}, n, 1);
  endtask

  typedef struct {
    logic [5:0] mode;
    logic       bmode;
    logic [2:0] sel;
    logic [2:0] exp_bgr;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int seen, pulses;
    // btn_state = 2'b10, counter1 = 1, counter0 = 0 when the table runs
    vecs[0] = '{6'b00_00_00, 1'b0, 3'd0, 3'b111, 8'd2};
    vecs[1] = '{6'b01_01_01, 1'b1, 3'd1, 3'b000, 8'd1};
    vecs[2] = '{6'b00_11_00, 1'b1, 3'd0, 3'b101, 8'd0};
    vecs[3] = '{6'b11_00_11, 1'b1, 3'd5, 3'b111, 8'd0};
    vecs[4] = '{6'b00_11_01, 1'b1, 3'd1, 3'b100, 8'd1};
    vecs[5] = '{6'b11_11_11, 1'b0, 3'd0, 3'b101, 8'd2};

    rst_n = 1'b0; btn_raw = 2'b11; led_mode = '0;
    bits_mode = 1'b0; bits_sel = '0; cnt_clr = 1'b0;
    ticks(3);
    check("reset_state", btn_state, 0);
    check("reset_pulses", {btn_press, btn_release}, 0);
    check("reset_leds", {blue, green, red}, 3'b111);
    check("reset_bits", bits, 0);
    rst_n = 1'b1;
    ticks(2);

    btn_raw = 2'b10;
    expect_pulse("press0", 1'b0, 0, 6, 10);
    check("press0_state", btn_state[0], 1);
    btn_raw = 2'b11;
    expect_pulse("release0", 1'b1, 0, 6, 10);
    check("release0_state", btn_state[0], 0);

    pulses = 0;
    btn_raw = 2'b10; for (int i = 0; i < 3; i++) begin tick(); pulses += int'(btn_press[0]); end
    btn_raw = 2'b11; tick(); pulses += int'(btn_press[0]);
    check("bounce_early", pulses, 0);
    btn_raw = 2'b10;
    expect_pulse("bounce", 1'b0, 0, 6, 10);
    btn_raw = 2'b11;
    ticks(10);

    bits_mode = 1'b1; bits_sel = 3'd1;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int p = 0; p < 257; p++) begin
      btn_raw[1] = 1'b0; ticks(8);
      btn_raw[1] = 1'b1; ticks(8);
    end
    ticks(2);
    check("wrap257", bits, 1);

    btn_raw[1] = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin tick(); if (btn_press[1]) seen = 1; end
    check("press1_seen", seen, 1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    ticks(2);
    check("clr_priority", bits, 0);
    btn_raw[1] = 1'b1; ticks(8);

    btn_raw[1] = 1'b0; ticks(8);
    check("sel1", bits, 1);
    bits_sel = 3'd5; tick();
    check("sel5", bits, 0);

    for (int v = 0; v < 6; v++) begin
      led_mode = vecs[v].mode; bits_mode = vecs[v].bmode; bits_sel = vecs[v].sel;
      tick();
      check($sformatf("vec%0d_leds", v), {blue, green, red}, vecs[v].exp_bgr);
      check($sformatf("vec%0d_bits", v), bits, vecs[v].exp_bits);
    end

    btn_raw = 2'b10; led_mode = 6'b11_10_01; bits_mode = 1'b0; bits_sel = '0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check($sformatf("red_c%0d", c), red, 0);
      check($sformatf("green_c%0d", c), green, (((c - 1) / BD) % 2 == 1) ? 0 : 1);
      check($sformatf("blue_c%0d", c), blue, (c >= 7) ? 0 : 1);
    end
    btn_raw = 2'b11;
    seen = 0;
    for (int c = 0; c < 12 && seen == 0; c++) begin tick(); if (!btn_state[0]) seen = 1; end
    check("follow_fall_seen", seen, 1);
    check("blue_still_lit", blue, 0);
    tick();
    check("blue_unlit", blue, 1);
    ticks(4);

    btn_raw = 2'b10; ticks(5);
    rst_n = 1'b0; tick();
    check("midreset_press", btn_press, 0);
    check("midreset_state", btn_state, 0);
    rst_n = 1'b1;
    expect_pulse("after_reset", 1'b0, 0, 6, 10);

    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(19) == 0) led_mode = 6'($urandom);
      bits_mode = 1'($urandom);
      bits_sel  = 3'($urandom);
      cnt_clr   = ($urandom_range(39) == 0);
      rst_n     = ($urandom_range(299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
